// File: rtl/lcd_refresh_ctrl.sv
// rtl/lcd_refresh_ctrl.sv - 2x16 frame buffer that keeps an HD44780 I2C LCD driver in sync
//
// Purpose: holds 32 character cells written by a client, powers up and
// initialises the LCD driver, then streams every dirty cell to the glass,
// issuing a DDRAM set-address instruction only when the LCD cursor is not
// already at the cell being sent.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   wr_en     client write strobe (always accepted, any state)
//   wr_addr   cell index: 0-15 line 0, 16-31 line 1
//   wr_char   character code for the cell
//   lcd_cmd   driver command: 0 IDLE, 1 INIT, 2 WRITE, 3 INSTR
//   lcd_data  character (WRITE) or instruction byte (INSTR)
//   lcd_busy  driver busy handshake
//   ready     driver initialisation has completed
//   idle      ready, nothing dirty, scanning
//   error     sticky handshake timeout flag, cleared only by rst

module lcd_refresh_ctrl #(
   parameter int POWERUP_CYCLES = 100_000_000,
   parameter int ACK_TIMEOUT    = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_char,
   output logic [1:0] lcd_cmd,
   output logic [7:0] lcd_data,
   input  logic       lcd_busy,
   output logic       ready,
   output logic       idle,
   output logic       error
);

   localparam int PW_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
   localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [PW_W-1:0] PW_RELOAD = PW_W'(POWERUP_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

   localparam logic [1:0] CMD_IDLE  = 2'd0;
   localparam logic [1:0] CMD_INIT  = 2'd1;
   localparam logic [1:0] CMD_WRITE = 2'd2;
   localparam logic [1:0] CMD_INSTR = 2'd3;

   typedef enum logic [2:0] {
      S_PWR_WAIT  = 3'd0,
      S_INIT_REQ  = 3'd1,
      S_INIT_WAIT = 3'd2,
      S_SCAN      = 3'd3,
      S_ADDR_REQ  = 3'd4,
      S_ADDR_WAIT = 3'd5,
      S_CHAR_REQ  = 3'd6,
      S_CHAR_WAIT = 3'd7
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PW_W-1:0]   r_pw_cnt;
   logic [TO_W-1:0]   r_to_cnt;
   logic [7:0]        r_buf [32];
   logic [31:0]       r_dirty;
   logic [31:0]       w_dirty_nxt;
   logic [4:0]        r_ptr;
   logic [4:0]        r_pos;
   logic [7:0]        r_char;
   logic [6:0]        r_target;
   logic [6:0]        r_cursor;
   logic              r_ready;
   logic              r_idle;
   logic              r_error;

   logic              w_in_req;
   logic              w_timeout;
   logic              w_scan_hit;
   logic [6:0]        w_scan_target;
   logic [1:0]        w_cmd;
   logic [7:0]        w_data;

   assign w_in_req   = (r_state == S_INIT_REQ) || (r_state == S_ADDR_REQ) ||
                       (r_state == S_CHAR_REQ);
   // Only a REQ that never saw busy can time out; busy=1 wins on the last cycle.
   assign w_timeout  = w_in_req && !lcd_busy && (r_to_cnt == TO_LAST);
   assign w_scan_hit = r_dirty[r_ptr];
   // Line 1 lives at DDRAM 0x40; line 0 at 0x00.
   assign w_scan_target = r_ptr[4] ? {3'b100, r_ptr[3:0]} : {3'b000, r_ptr[3:0]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_PWR_WAIT;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_PWR_WAIT:  if (r_pw_cnt == '0) w_state_nxt = S_INIT_REQ;
         S_INIT_REQ:  if (lcd_busy) w_state_nxt = S_INIT_WAIT;
                      else if (w_timeout) w_state_nxt = S_PWR_WAIT;
         S_INIT_WAIT: if (!lcd_busy) w_state_nxt = S_SCAN;
         S_SCAN:      if (w_scan_hit)
                         w_state_nxt = (r_cursor != w_scan_target) ? S_ADDR_REQ : S_CHAR_REQ;
         S_ADDR_REQ:  if (lcd_busy) w_state_nxt = S_ADDR_WAIT;
                      else if (w_timeout) w_state_nxt = S_PWR_WAIT;
         S_ADDR_WAIT: if (!lcd_busy) w_state_nxt = S_CHAR_REQ;
         S_CHAR_REQ:  if (lcd_busy) w_state_nxt = S_CHAR_WAIT;
                      else if (w_timeout) w_state_nxt = S_PWR_WAIT;
         S_CHAR_WAIT: if (!lcd_busy) w_state_nxt = S_SCAN;
         default:     w_state_nxt = S_PWR_WAIT;
      endcase
   end

   // Output logic: a command is presented only while in a REQ state, so it
   // drops to IDLE on the edge that samples busy, times out, or resets.
   always_comb begin
      w_cmd  = CMD_IDLE;
      w_data = 8'h00;
      case (r_state)
         S_INIT_REQ: w_cmd = CMD_INIT;
         S_ADDR_REQ: begin
            w_cmd  = CMD_INSTR;
            w_data = 8'h80 | {1'b0, r_target};
         end
         S_CHAR_REQ: begin
            w_cmd  = CMD_WRITE;
            w_data = r_char;
         end
         default: ;
      endcase
   end

   assign lcd_cmd  = w_cmd;
   assign lcd_data = w_data;
   assign ready    = r_ready;
   assign idle     = r_idle;
   assign error    = r_error;

   // Dirty bits: timeout marks everything, scan clears one, client write sets
   // last so a same-cycle rewrite of the cell being picked up is not lost.
   always_comb begin
      w_dirty_nxt = r_dirty;
      if (w_timeout) w_dirty_nxt = '1;
      if (r_state == S_SCAN && w_scan_hit) w_dirty_nxt[r_ptr] = 1'b0;
      if (wr_en) w_dirty_nxt[wr_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
         r_dirty <= '1;
      end else begin
         if (wr_en) r_buf[wr_addr] <= wr_char;
         r_dirty <= w_dirty_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pw_cnt <= PW_RELOAD;
         r_to_cnt <= '0;
         r_ptr    <= '0;
         r_pos    <= '0;
         r_char   <= 8'h00;
         r_target <= 7'h00;
         r_cursor <= 7'h00;
         r_ready  <= 1'b0;
         r_idle   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         if (w_timeout)
            r_pw_cnt <= PW_RELOAD;
         else if (r_state == S_PWR_WAIT && r_pw_cnt != '0)
            r_pw_cnt <= r_pw_cnt - 1'b1;

         if (!w_in_req || lcd_busy || w_timeout) r_to_cnt <= '0;
         else                                    r_to_cnt <= r_to_cnt + 1'b1;

         if (w_timeout) begin
            r_error <= 1'b1;
            r_ready <= 1'b0;
         end

         if (r_state == S_INIT_WAIT && !lcd_busy) begin
            r_ready  <= 1'b1;
            r_cursor <= 7'h00;
         end

         if (r_state == S_SCAN) begin
            if (w_scan_hit) begin
               r_pos    <= r_ptr;
               r_char   <= r_buf[r_ptr];
               r_target <= w_scan_target;
            end else begin
               r_ptr <= r_ptr + 5'd1;
            end
         end

         // The LCD auto-increments its address after a character write.
         if (r_state == S_CHAR_WAIT && !lcd_busy) begin
            r_cursor <= r_target + 7'd1;
            r_ptr    <= r_pos + 5'd1;
         end

         r_idle <= r_ready && (r_dirty == '0) && (r_state == S_SCAN);
      end
   end

endmodule
